tick_scheduler: RTL
===================

# tick_scheduler

Four-channel tick scheduler that shares one free-running base prescaler between independent timing channels. Each channel has its own programmable period, counted in base ticks, and runs either periodically or as a one-shot. Each channel emits single-cycle enable pulses to the shift and detection logic downstream. Channels are configured through a valid/ready command port, so one block replaces the separate per-function clock dividers.

## Interface
- BASE_DIV, 50000: clocks per base tick (1 ms at 50 MHz); legal range ≥ 2.
- PER_W, 16: width of the per-channel period, counted in base ticks.
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  command present.
- cfg_ready  out  1  block can accept a command.
- cfg_ch  in  2  target channel, 0..3.
- cfg_op  in  2  command opcode:
  - 00: LOAD period.
  - 01: START periodic.
  - 10: START one-shot.
  - 11: STOP.
- cfg_data  in  PER_W  period value; used by LOAD only.
- base_tick  out  1  one-cycle pulse every BASE_DIV clocks.
- tick_en  out  4  per-channel one-cycle enable pulse.
- busy  out  4  per-channel running flag.

## Operation
- Reset (clr=1, asynchronous):
  - prescaler = 0, base_tick = 0, cfg_ready = 0.
  - All channels: period = 1, count = 0, busy = 0, mode = periodic.
  - tick_en = 0.
- Prescaler:
  - Counts 0..BASE_DIV-1 and wraps to 0.
  - base_tick = 1 exactly in the cycle where the count equals BASE_DIV-1.
  - Never gated by channel state.
- Handshake:
  - A command is accepted on an edge where cfg_valid & cfg_ready = 1.
  - cfg_ready is registered. It is 1 in every cycle except the cycle immediately after an acceptance, so the maximum command rate is one per two clocks.
  - cfg_ready first rises on the first edge after clr falls.
  - Inputs are ignored while cfg_ready = 0.
- LOAD:
  - period[ch] = cfg_data; a value of 0 is stored as 1.
  - Does not alter a countdown in progress. The new value takes effect at the next START or periodic reload.
- START (periodic or one-shot):
  - count[ch] = period[ch], busy[ch] = 1, mode latched.
  - Accepted while already busy: restarts from the full period and drops any partial count.
- STOP:
  - busy[ch] = 0, count = 0. No pulse is issued.
- Counting, per busy channel on each edge where base_tick = 1:
  - count > 1: decrement.
  - count == 1: raise tick_en[ch] for the next cycle.
    - Periodic: reload count = period (the current register value).
    - One-shot: busy = 0.
- Simultaneous events:
  - START or STOP accepted on the same edge as base_tick: the command wins for that channel, and that base_tick is not counted.
  - STOP on the same edge as the expiring base_tick: no pulse.
  - LOAD on the same edge as a periodic reload: the reload uses the old period; the new value applies from the following reload.
  - A command to channel ch never affects the other channels.
- Multiple channels may pulse in the same cycle; tick_en bits are independent.

## Timing
- All outputs are registered. There is no combinational path from cfg_* to any output.
- START accepted at edge E0: busy = 1 from the cycle after E0.
- The first tick_en pulse is high in the cycle after the edge that samples the P-th base_tick following E0. It lags that base_tick by exactly one clock.
- Periodic spacing: consecutive pulses are exactly P × BASE_DIV clocks apart.
- One-shot: busy falls on the same edge that raises tick_en.
- tick_en is always exactly one clock wide.
- Asserting clr mid-countdown clears all outputs immediately, without waiting for an edge.

## Test plan
Use BASE_DIV=4 in simulation.
- Reset release, then idle:
  - base_tick pulses every 4 clocks.
  - cfg_ready = 1 after the first edge.
  - tick_en and busy stay 0.
- LOAD ch0 = 3, then START periodic ch0:
  - tick_en[0] pulses every 12 clocks, each one clock after every 3rd base_tick.
  - busy[0] stays 1.
- LOAD ch1 = 0, then START one-shot ch1:
  - Exactly one tick_en[1] pulse (period clamped to 1) one clock after the next counted base_tick.
  - busy[1] falls with the pulse.
- Ch2 periodic with P=2:
  - STOP issued on the edge of the expiring base_tick gives no pulse and busy[2] = 0.
  - LOAD 5 mid-count leaves the current interval at 2 and makes later intervals 5.
- All four channels running with P=1:
  - All tick_en bits pulse together every 4 clocks.
  - Back-to-back cfg_valid is accepted only every other cycle.
- Assert clr mid-countdown with ch3 busy:
  - busy, tick_en, base_tick and cfg_ready go to 0 immediately.
  - After release, ch3 stays idle and its period reads back as 1 (first START gives a P=1 pulse).

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: four timing channels sharing one free-running base prescaler.
// Each channel counts a programmable number of base ticks and emits one-cycle
// enable pulses, either periodically or once. Channels are configured through
// a valid/ready command port that accepts at most one command per two clocks.
module tick_scheduler #(
    parameter int BASE_DIV = 50000,
    parameter int PER_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic [1:0]       cfg_op,
    input  logic [PER_W-1:0] cfg_data,
    output logic             base_tick,
    output logic [3:0]       tick_en,
    output logic [3:0]       busy
);

    localparam int PRE_W = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(BASE_DIV - 1);

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_START_P = 2'b01,
        OP_START_O = 2'b10,
        OP_STOP    = 2'b11
    } op_e;

    // Prescaler and handshake state
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             base_tick_q, base_tick_d;
    logic             cfg_ready_q, cfg_ready_d;

    // Per-channel state
    logic [PER_W-1:0] period_q [4];
    logic [PER_W-1:0] period_d [4];
    logic [PER_W-1:0] count_q  [4];
    logic [PER_W-1:0] count_d  [4];
    logic [3:0]       busy_q, busy_d;
    logic [3:0]       one_shot_q, one_shot_d;
    logic [3:0]       tick_en_q, tick_en_d;

    logic       accept;
    logic [3:0] cmd_hit;
    op_e        cmd_op;

    assign accept = cfg_valid & cfg_ready_q;
    assign cmd_op = op_e'(cfg_op);

    // Decode which channel, if any, the accepted command targets
    always_comb begin
        cmd_hit = '0;
        for (int i = 0; i < 4; i++) begin
            cmd_hit[i] = accept && (cfg_ch == 2'(i));
        end
    end

    // Free-running prescaler; base_tick is registered so it is high while the count sits at its last value
    always_comb begin
        presc_d     = (presc_q == LAST_PRE) ? '0 : presc_q + PRE_W'(1);
        base_tick_d = (presc_d == LAST_PRE);
        cfg_ready_d = ~accept;
    end

    // Channel next state: commands take priority over the base tick countdown for their own channel
    always_comb begin
        period_d   = period_q;
        count_d    = count_q;
        busy_d     = busy_q;
        one_shot_d = one_shot_q;
        tick_en_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (cmd_hit[i] && (cmd_op == OP_LOAD)) begin
                period_d[i] = (cfg_data == '0) ? PER_W'(1) : cfg_data;
            end
            if (cmd_hit[i] && ((cmd_op == OP_START_P) || (cmd_op == OP_START_O))) begin
                count_d[i]    = period_q[i];
                busy_d[i]     = 1'b1;
                one_shot_d[i] = (cmd_op == OP_START_O);
            end else if (cmd_hit[i] && (cmd_op == OP_STOP)) begin
                count_d[i] = '0;
                busy_d[i]  = 1'b0;
            end else if (busy_q[i] && base_tick_q) begin
                if (count_q[i] > PER_W'(1)) begin
                    count_d[i] = count_q[i] - PER_W'(1);
                end else begin
                    tick_en_d[i] = 1'b1;
                    if (one_shot_q[i]) begin
                        busy_d[i]  = 1'b0;
                        count_d[i] = '0;
                    end else begin
                        count_d[i] = period_q[i];
                    end
                end
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= '0;
            one_shot_q  <= '0;
            tick_en_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                period_q[i] <= PER_W'(1);
                count_q[i]  <= '0;
            end
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            one_shot_q  <= one_shot_d;
            tick_en_q   <= tick_en_d;
            for (int i = 0; i < 4; i++) begin
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign base_tick = base_tick_q;
    assign tick_en   = tick_en_q;
    assign busy      = busy_q;

endmodule
